reg_file_sb: RTL
================

Name: reg_file_sb

Overview:
- Parametrised register file for the simple processor datapath; the next generation of the 2-entry, 8-bit register file.
- Adds configurable width and depth, a hardwired zero register, write-to-read bypass, and a load scoreboard.
- The scoreboard tracks registers awaiting DataMemory read data and raises a stall hazard to the control path.
- Sits between InstructionMemory decode and the ALU/DestMux path; the write port is fed from the Mem_to_Reg mux.

Parameters:
- DATA_W, 8, register width in bits.
- NUM_REGS, 4, number of registers; power of 2, minimum 2.
- ZERO_R0, 1, when 1 register 0 reads as 0 and ignores writes and pend requests.
- BYPASS, 1, when 1 a same-cycle write is forwarded to the read ports.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- read_reg1  in  AW  read port 1 address. AW = $clog2(NUM_REGS), derived localparam.
- read_reg2  in  AW  read port 2 address.
- rd1_en  in  1  port 1 operand is actually used; qualifies the hazard.
- rd2_en  in  1  port 2 operand is actually used; qualifies the hazard.
- write_reg  in  AW  write address.
- reg_write  in  1  write enable.
- write_data  in  DATA_W  write data.
- pend_set  in  1  load issued; mark pend_reg pending.
- pend_reg  in  AW  destination register of the issued load.
- read_data1  out  DATA_W  port 1 data, combinational.
- read_data2  out  DATA_W  port 2 data, combinational.
- hazard  out  1  an enabled read targets a pending register; control stalls.
- pend_vec  out  NUM_REGS  pending bit per register, registered.

Behaviour:
- Reset (rst_n low, asynchronous): all registers go to 0 and pend_vec goes to 0. read_data1/2 then reflect 0 or bypassed data. Reset asserted mid-operation discards all pending state immediately.
- Write: at posedge clk, when reg_write=1, regs[write_reg] <= write_data. One-cycle write latency.
- Read: combinational. read_dataN = regs[read_regN], with the following overrides:
  - If BYPASS=1, reg_write=1, write_reg==read_regN, and the write is not to a masked zero register, read_dataN = write_data.
  - If ZERO_R0=1 and read_regN==0, read_dataN = 0, overriding bypass.
- Both read ports may address the same register; both return identical data.
- Scoreboard, at posedge clk:
  - reg_write to register r clears pend_vec[r].
  - pend_set sets pend_vec[pend_reg].
  - Same register set and cleared in the same cycle: set wins, because a new load is outstanding.
  - Set and clear on different registers both take effect.
  - With ZERO_R0=1, bit 0 is never set.
  - pend_set on a register that is already pending: the bit stays 1 (no counting).
- hazard = (rd1_en & P(read_reg1)) | (rd2_en & P(read_reg2)).
  - P(r) = pend_vec[r] & ~(BYPASS & reg_write & write_reg==r).
  - A same-cycle writeback therefore resolves the hazard only when bypass is enabled.
  - A pend_set in the current cycle does not raise hazard until the next cycle.
- Width rules: write_data is stored unmodified. No sign or zero extension inside the block; the existing SignExt blocks upstream handle that.
- Boundaries:
  - Highest address NUM_REGS-1 is fully usable.
  - Out-of-range indices cannot occur (power-of-2 depth).
  - reg_write=0 with any write_reg has no effect on registers or scoreboard.

Decomposition:
- Shared package proc_pkg holds DATA_W_DEF=8, NUM_REGS_DEF=4, and a function computing AW from NUM_REGS.
- One natural sub-module: reg_scoreboard, containing pend_vec update and hazard generation (parameters NUM_REGS, ZERO_R0, BYPASS).
- Storage array and read muxing stay in reg_file_sb.

Test Plan:
- Reset and zero register: assert rst_n=0 mid-run with pend_vec=4'b0110 → pend_vec=0 and all reads 0 immediately. Then write r0=8'hAA → read r0 returns 8'h00.
- Write then read: write r2=8'h5C, read_reg1=2 next cycle → 8'h5C. Same cycle with BYPASS=1 → 8'h5C. With BYPASS=0 → old value 8'h00.
- Dual read: r1=8'h11, r3=8'hF3, read_reg1=1, read_reg2=3 → 8'h11/8'hF3. Both ports on r3 → 8'hF3 on both.
- Load hazard: pend_set r1, next cycle rd1_en=1, read_reg1=1 → hazard=1. Writeback r1=8'h7E with BYPASS=1 → hazard=0 same cycle and read_data1=8'h7E; pend_vec[1]=0 after the edge.
- Simultaneous events: pend_set r2 while reg_write r2=8'h01 → pend_vec[2]=1 and r2=8'h01. pend_set r3 with writeback r1 (r1 pending) → pend_vec=4'b1000.
- Parameter sweep: DATA_W=16, NUM_REGS=8, ZERO_R0=0 → write r0=16'hBEEF, r7=16'h1234 → read back exactly. pend_set r0 → hazard when rd2_en=1, read_reg2=0.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared datapath defaults and helpers for the processor register file.
package proc_pkg;

  localparam int unsigned DATA_W_DEF   = 8;
  localparam int unsigned NUM_REGS_DEF = 4;

  // Address width for a power-of-2 register count; never narrower than one bit.
  function automatic int unsigned addr_w(input int unsigned num_regs);
    return (num_regs <= 2) ? 1 : $clog2(num_regs);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Load scoreboard: one pending bit per register, plus the stall hazard derived from it.
module reg_scoreboard
  import proc_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter bit          ZERO_R0  = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned AW      = addr_w(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [AW-1:0]       read_reg1,
  input  logic [AW-1:0]       read_reg2,
  input  logic                rd1_en,
  input  logic                rd2_en,
  input  logic [AW-1:0]       write_reg,
  input  logic                reg_write,
  input  logic                pend_set,
  input  logic [AW-1:0]       pend_reg,
  output logic                hazard,
  output logic [NUM_REGS-1:0] pend_vec
);

  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [NUM_REGS-1:0] fwd_mask;
  logic [NUM_REGS-1:0] pend_eff;

  // Clear on writeback first so that a new load to the same register wins.
  always_comb begin
    pend_d = pend_q;
    if (reg_write) begin
      pend_d[write_reg] = 1'b0;
    end
    if (pend_set && !(ZERO_R0 && (pend_reg == '0))) begin
      pend_d[pend_reg] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // A forwarded writeback satisfies the pending load in the same cycle.
  always_comb begin
    fwd_mask = '0;
    if (BYPASS && reg_write) begin
      fwd_mask[write_reg] = 1'b1;
    end
  end

  assign pend_eff = pend_q & ~fwd_mask;
  assign hazard   = (rd1_en & pend_eff[read_reg1]) | (rd2_en & pend_eff[read_reg2]);
  assign pend_vec = pend_q;

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised two-read/one-write register file with zero register, bypass and load scoreboard.
module reg_file_sb
  import proc_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter bit          ZERO_R0  = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned AW      = addr_w(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [AW-1:0]       read_reg1,
  input  logic [AW-1:0]       read_reg2,
  input  logic                rd1_en,
  input  logic                rd2_en,
  input  logic [AW-1:0]       write_reg,
  input  logic                reg_write,
  input  logic [DATA_W-1:0]   write_data,
  input  logic                pend_set,
  input  logic [AW-1:0]       pend_reg,
  output logic [DATA_W-1:0]   read_data1,
  output logic [DATA_W-1:0]   read_data2,
  output logic                hazard,
  output logic [NUM_REGS-1:0] pend_vec
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic              wr_live;

  assign wr_live = reg_write && !(ZERO_R0 && (write_reg == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_live) begin
      regs_q[write_reg] <= write_data;
    end
  end

  // Zero-register masking takes priority over forwarding.
  always_comb begin
    read_data1 = regs_q[read_reg1];
    if (BYPASS && wr_live && (write_reg == read_reg1)) begin
      read_data1 = write_data;
    end
    if (ZERO_R0 && (read_reg1 == '0)) begin
      read_data1 = '0;
    end
  end

  always_comb begin
    read_data2 = regs_q[read_reg2];
    if (BYPASS && wr_live && (write_reg == read_reg2)) begin
      read_data2 = write_data;
    end
    if (ZERO_R0 && (read_reg2 == '0)) begin
      read_data2 = '0;
    end
  end

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ZERO_R0  (ZERO_R0),
    .BYPASS   (BYPASS)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .read_reg1 (read_reg1),
    .read_reg2 (read_reg2),
    .rd1_en    (rd1_en),
    .rd2_en    (rd2_en),
    .write_reg (write_reg),
    .reg_write (reg_write),
    .pend_set  (pend_set),
    .pend_reg  (pend_reg),
    .hazard    (hazard),
    .pend_vec  (pend_vec)
  );

endmodule
